// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM encoding, row drive
// patterns and the one-cold column decoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_t;

    localparam logic [3:0] ROW0_DRIVE  = 4'b1110;
    localparam int         ENTRY_WIDTH = 24;

    // Returns {valid, index}; only a single low column is a usable sample.
    function automatic logic [2:0] col_decode(input logic [3:0] col_n);
        logic [2:0] res;
        res = 3'b000;
        case (col_n)
            4'b1110: res = 3'b100;
            4'b1101: res = 3'b101;
            4'b1011: res = 3'b110;
            4'b0111: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/keypad_scan_tick.sv
// Free-running divider producing a one-cycle scan-tick enable every DIVISOR
// clocks; used as a clock enable, never as a clock.
module scan_tick
    import keypad_pkg::*;
#(
    parameter logic [31:0] DIVISOR = 32'hFFFF
) (
    input  logic clk,
    input  logic srst,
    output logic o_tick
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    assign o_tick = (cnt_q == DIVISOR - 32'd1);

    always_comb begin
        cnt_d = cnt_q + 32'd1;
        if (o_tick) begin
            cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_input.sv
// 4x4 hex keypad scanner with press/release debounce; confirmed keys shift one
// nybble into a 24-bit entry register that the CPU reads over o_BUS.
module keypad_input
    import keypad_pkg::*;
#(
    parameter int          DATA_WIDTH     = 8,
    parameter logic [31:0] DIVISOR        = 32'hFFFF,
    parameter int          DEBOUNCE_TICKS = 4
) (
    input  logic                  i_SYS_CLOCK,
    input  logic                  i_RESET,
    input  logic [3:0]            i_COL,
    input  logic                  i_CLEAR,
    input  logic                  i_WRITE_BUS,
    output logic [3:0]            o_ROW,
    output logic [DATA_WIDTH-1:0] o_BUS,
    output logic                  o_KEY_VALID,
    output logic [3:0]            o_KEY_CODE,
    output logic                  o_READY
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    logic                   tick;
    logic [3:0]             col_meta_q, col_sync_q;
    kp_state_t              state_q, state_d;
    logic [1:0]             row_idx_q, row_idx_d;
    logic [1:0]             col_idx_q, col_idx_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [3:0]             row_q, row_d;
    logic                   key_valid_q, key_valid_d;
    logic [3:0]             key_code_q, key_code_d;
    logic                   ready_q, ready_d;
    logic [ENTRY_WIDTH-1:0] value_q, value_d;

    logic [2:0]             sample;
    logic                   all_ones;
    logic                   confirm;
    logic [3:0]             confirm_code;
    logic                   unused_top_nybble;

    scan_tick #(
        .DIVISOR (DIVISOR)
    ) u_scan_tick (
        .clk    (i_SYS_CLOCK),
        .srst   (i_RESET),
        .o_tick (tick)
    );

    assign sample   = col_decode(col_sync_q);
    assign all_ones = (col_sync_q == 4'hF);

    always_comb begin
        state_d      = state_q;
        row_idx_d    = row_idx_q;
        col_idx_d    = col_idx_q;
        count_d      = count_q;
        confirm      = 1'b0;
        confirm_code = {row_idx_q, col_idx_q};

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (sample[2]) begin
                        col_idx_d    = sample[1:0];
                        count_d      = CNT_ONE;
                        confirm_code = {row_idx_q, sample[1:0]};
                        if (DEBOUNCE_TICKS == 1) begin
                            confirm = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_PRESS_DB;
                        end
                    end else begin
                        row_idx_d = row_idx_q + 2'd1;
                    end
                end
                ST_PRESS_DB: begin
                    if (sample[2] && (sample[1:0] == col_idx_q)) begin
                        if (count_q >= CNT_LAST) begin
                            confirm = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            count_d = count_q + CNT_ONE;
                        end
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
                ST_HELD: begin
                    if (all_ones) begin
                        count_d = CNT_ONE;
                        if (DEBOUNCE_TICKS == 1) begin
                            state_d   = ST_SCAN;
                            row_idx_d = 2'd0;
                        end else begin
                            state_d = ST_RELEASE_DB;
                        end
                    end
                end
                default: begin
                    if (!all_ones) begin
                        state_d = ST_HELD;
                    end else if (count_q >= CNT_LAST) begin
                        state_d   = ST_SCAN;
                        row_idx_d = 2'd0;
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
            endcase
        end

        row_d       = row_drive(row_idx_d);
        key_valid_d = confirm;
        key_code_d  = confirm ? confirm_code : key_code_q;
        value_d     = value_q;
        ready_d     = ready_q;

        // Bus read clears READY, a confirm sets it, and a clear beats both.
        if (i_WRITE_BUS) begin
            ready_d = 1'b0;
        end
        if (confirm) begin
            value_d = {value_q[ENTRY_WIDTH-5:0], confirm_code};
            ready_d = 1'b1;
        end
        if (i_CLEAR) begin
            value_d = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge i_SYS_CLOCK) begin
        if (i_RESET) begin
            col_meta_q  <= 4'h0;
            col_sync_q  <= 4'h0;
            state_q     <= ST_SCAN;
            row_idx_q   <= 2'd0;
            col_idx_q   <= 2'd0;
            count_q     <= '0;
            row_q       <= ROW0_DRIVE;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            ready_q     <= 1'b0;
            value_q     <= '0;
        end else begin
            col_meta_q  <= i_COL;
            col_sync_q  <= col_meta_q;
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            count_q     <= count_d;
            row_q       <= row_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            ready_q     <= ready_d;
            value_q     <= value_d;
        end
    end

    // The oldest nybble is shifted out and is only visible on a wide bus.
    assign unused_top_nybble = ^value_q[ENTRY_WIDTH-1:ENTRY_WIDTH-4];

    assign o_ROW       = row_q;
    assign o_KEY_VALID = key_valid_q;
    assign o_KEY_CODE  = key_code_q;
    assign o_READY     = ready_q;

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bus
        if (gi < ENTRY_WIDTH) begin : g_data
            assign o_BUS[gi] = i_WRITE_BUS & value_q[gi];
        end else begin : g_zero
            assign o_BUS[gi] = 1'b0;
        end
    end

endmodule
